// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, op encodings and the packed issue-entry type.
package alu_pkg;
   localparam int DATA_W     = 32;
   localparam int ALU_CTRL_W = 4;
   localparam int BONUS_W    = 3;
   localparam logic [ALU_CTRL_W-1:0] OP_AND = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] OP_OR  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] OP_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] OP_SUB = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] OP_SLT = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] OP_NOR = 4'b1100;
   typedef struct packed {
      logic [DATA_W-1:0]     src1;
      logic [DATA_W-1:0]     src2;
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [BONUS_W-1:0]    bonus_ctrl;
      logic                  fwd1;
      logic                  fwd2;
   } issue_entry_t;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decode-side, ALU-side and status signals of the issue stage.
interface alu_issue_stage_if import alu_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_src1;
   logic [WIDTH-1:0]      in_src2;
   logic [ALU_CTRL_W-1:0] in_alu_ctrl;
   logic [BONUS_W-1:0]    in_bonus_ctrl;
   logic                  in_fwd1;
   logic                  in_fwd2;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_src1;
   logic [WIDTH-1:0]      out_src2;
   logic [ALU_CTRL_W-1:0] out_alu_ctrl;
   logic [BONUS_W-1:0]    out_bonus_ctrl;
   logic [WIDTH-1:0]      alu_result;
   logic                  alu_overflow;
   logic                  clear_sticky;
   logic                  ovf_sticky;
   logic [CNT_W-1:0]      op_count;
   modport slave (
      input  in_valid, in_src1, in_src2, in_alu_ctrl, in_bonus_ctrl, in_fwd1, in_fwd2,
      input  out_ready, alu_result, alu_overflow, clear_sticky,
      output in_ready, out_valid, out_src1, out_src2, out_alu_ctrl, out_bonus_ctrl,
      output ovf_sticky, op_count
   );
   modport master (
      output in_valid, in_src1, in_src2, in_alu_ctrl, in_bonus_ctrl, in_fwd1, in_fwd2,
      output out_ready, alu_result, alu_overflow, clear_sticky,
      input  in_ready, out_valid, out_src1, out_src2, out_alu_ctrl, out_bonus_ctrl,
      input  ovf_sticky, op_count
   );
endinterface

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: power-of-two circular buffer of issue entries with occupancy count.
module alu_issue_fifo import alu_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  issue_entry_t             wr_data,
   output issue_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] P1 = 1;
   localparam logic [PW:0]   C1 = 1;
   issue_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + P1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + P1 : rd_ptr_q;
      count_d  = (push && !pop) ? count_q + C1 : (pop && !push) ? count_q - C1 : count_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // Storage needs no reset: the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers decoded ALU ops, forwards the last result into operands,
// and tracks issued-op count and sticky overflow from the ALU feedback.
module alu_issue_stage import alu_pkg::*; #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   alu_issue_stage_if.slave io
);
   localparam logic [$clog2(DEPTH):0] FULL = DEPTH;
   localparam logic [CNT_W-1:0]       CNT1 = 1;
   issue_entry_t                wr_data, head;
   logic [$clog2(DEPTH):0]      count;
   logic                        push, pop;
   logic [WIDTH-1:0]            last_result_q, last_result_d;
   logic [CNT_W-1:0]            op_count_q, op_count_d;
   logic                        ovf_sticky_q, ovf_sticky_d;
   // Readiness depends on occupancy only, so a full buffer never admits a push on a pop cycle.
   assign io.in_ready  = count != FULL;
   assign io.out_valid = count != '0;
   assign push = io.in_valid && io.in_ready;
   assign pop  = io.out_valid && io.out_ready;
   assign wr_data = '{src1: io.in_src1, src2: io.in_src2, alu_ctrl: io.in_alu_ctrl,
                      bonus_ctrl: io.in_bonus_ctrl, fwd1: io.in_fwd1, fwd2: io.in_fwd2};
   alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_data),
      .head    (head),
      .count   (count)
   );
   always_comb begin
      io.out_src1       = !io.out_valid ? '0 : head.fwd1 ? last_result_q : head.src1;
      io.out_src2       = !io.out_valid ? '0 : head.fwd2 ? last_result_q : head.src2;
      io.out_alu_ctrl   = io.out_valid ? head.alu_ctrl : '0;
      io.out_bonus_ctrl = io.out_valid ? head.bonus_ctrl : '0;
      last_result_d     = pop ? io.alu_result : last_result_q;
      op_count_d        = pop ? op_count_q + CNT1 : op_count_q;
      ovf_sticky_d      = (pop && io.alu_overflow) || (ovf_sticky_q && !io.clear_sticky);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_result_q <= '0;
         op_count_q    <= '0;
         ovf_sticky_q  <= 1'b0;
      end else begin
         last_result_q <= last_result_d;
         op_count_q    <= op_count_d;
         ovf_sticky_q  <= ovf_sticky_d;
      end
   end
   assign io.ovf_sticky = ovf_sticky_q;
   assign io.op_count   = op_count_q;
endmodule
